// File: rtl/seven_seg_pair_reader_if.sv
// Bus between a HEX segment source and the seven-segment pair reader.
// The master drives segment patterns and the strobe; the slave returns the decoded result.
interface seven_seg_pair_reader_if;
  logic [6:0] i_seg_ten;
  logic [6:0] i_seg_one;
  logic       i_sample;
  logic [6:0] o_value;
  logic       o_valid;
  logic       o_err;
  logic       o_locked;

  modport master (
    output i_seg_ten, i_seg_one, i_sample,
    input  o_value, o_valid, o_err, o_locked
  );

  modport slave (
    input  i_seg_ten, i_seg_one, i_sample,
    output o_value, o_valid, o_err, o_locked
  );
endinterface

// File: rtl/seven_seg_pair_reader.sv
// Decodes a (tens, ones) pair of active-low DE2_115 segment patterns into 0..99 once stable.
// Optional macro SEVEN_SEG_RANGE_CHECK_EN rejects decoded values above 32 as illegal.
module seven_seg_pair_reader #(
  parameter int unsigned STABLE_CNT = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  seven_seg_pair_reader_if.slave bus
);

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned PAIR_W = 2 * SEG_W;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned VAL_W  = 7;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CNT);
`ifdef SEVEN_SEG_RANGE_CHECK_EN
  localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(32);
`endif

  typedef enum logic [1:0] {ST_EMPTY, ST_SETTLING, ST_LOCKED} state_t;

  // Returns {legal, digit}; anything outside the ten patterns is illegal.
  function automatic logic [DIG_W:0] seg_decode(input logic [SEG_W-1:0] seg);
    case (seg)
      7'b1000000: seg_decode = {1'b1, 4'd0};
      7'b1111001: seg_decode = {1'b1, 4'd1};
      7'b0100100: seg_decode = {1'b1, 4'd2};
      7'b0110000: seg_decode = {1'b1, 4'd3};
      7'b0011001: seg_decode = {1'b1, 4'd4};
      7'b0010010: seg_decode = {1'b1, 4'd5};
      7'b0000010: seg_decode = {1'b1, 4'd6};
      7'b1011000: seg_decode = {1'b1, 4'd7};
      7'b0000000: seg_decode = {1'b1, 4'd8};
      7'b0010000: seg_decode = {1'b1, 4'd9};
      default:    seg_decode = '0;
    endcase
  endfunction

  logic                 cap_v;
  logic [SEG_W-1:0]     cap_ten, cap_one;
  logic                 dec_v, dec_legal;
  logic [DIG_W-1:0]     dec_ten, dec_one;
  logic [PAIR_W-1:0]    dec_raw;
  logic [DIG_W:0]       ten_dec_c, one_dec_c;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc_c;
  logic [PAIR_W-1:0]    cand, cand_n;
  logic                 report_c, pair_ok_c;
  logic [VAL_W-1:0]     sum_c;
  logic [VAL_W-1:0]     value_q, value_n;
  logic                 valid_q, valid_n, err_q, err_n, locked_q, locked_n;

  always_comb begin
    ten_dec_c = seg_decode(cap_ten);
    one_dec_c = seg_decode(cap_one);
  end

  // Capture and decode stages; no backpressure, a new strobe may arrive every cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_v     <= 1'b0;
      cap_ten   <= '0;
      cap_one   <= '0;
      dec_v     <= 1'b0;
      dec_legal <= 1'b0;
      dec_ten   <= '0;
      dec_one   <= '0;
      dec_raw   <= '0;
    end else begin
      cap_v <= bus.i_sample;
      if (bus.i_sample) begin
        cap_ten <= bus.i_seg_ten;
        cap_one <= bus.i_seg_one;
      end
      dec_v <= cap_v;
      if (cap_v) begin
        dec_legal <= ten_dec_c[DIG_W] & one_dec_c[DIG_W];
        dec_ten   <= ten_dec_c[DIG_W-1:0];
        dec_one   <= one_dec_c[DIG_W-1:0];
        dec_raw   <= {cap_ten, cap_one};
      end
    end
  end

  // Stability FSM state register, together with the registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_EMPTY;
      cnt      <= '0;
      cand     <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cand     <= cand_n;
      value_q  <= value_n;
      valid_q  <= valid_n;
      err_q    <= err_n;
      locked_q <= locked_n;
    end
  end

  // Next state: a new pair restarts the count at 1, so STABLE_CNT=1 reports it immediately.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cand_n    = cand;
    report_c  = 1'b0;
    cnt_inc_c = (cnt >= STABLE_C) ? STABLE_C : cnt + CNT_W'(1);
    if (dec_v) begin
      if (state == ST_EMPTY || dec_raw != cand) begin
        cand_n   = dec_raw;
        cnt_n    = CNT_W'(1);
        report_c = (STABLE_C == CNT_W'(1));
        state_n  = report_c ? ST_LOCKED : ST_SETTLING;
      end else if (state == ST_SETTLING) begin
        cnt_n    = cnt_inc_c;
        report_c = (cnt_inc_c == STABLE_C);
        state_n  = report_c ? ST_LOCKED : ST_SETTLING;
      end
    end
  end

  always_comb begin
    sum_c = VAL_W'(dec_ten) * VAL_W'(10) + VAL_W'(dec_one);
`ifdef SEVEN_SEG_RANGE_CHECK_EN
    pair_ok_c = dec_legal && (sum_c <= MAX_VAL);
`else
    pair_ok_c = dec_legal;
`endif
  end

  // Output logic: one pulse per entry into LOCKED; lock is lost whenever FSM leaves LOCKED.
  always_comb begin
    value_n  = value_q;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    locked_n = locked_q && (state_n == ST_LOCKED);
    if (report_c) begin
      if (pair_ok_c) begin
        valid_n  = 1'b1;
        value_n  = sum_c;
        locked_n = 1'b1;
      end else begin
        err_n    = 1'b1;
        locked_n = 1'b0;
      end
    end
  end

  assign bus.o_value  = value_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_err    = err_q;
  assign bus.o_locked = locked_q;

endmodule

// File: tb/tb_seven_seg_pair_reader.sv
// Bench for seven_seg_pair_reader: two instances (STABLE_CNT 4 and 1) share directed and random
// stimulus and are compared against a run-length reference model with a two-cycle delay line.
module tb_seven_seg_pair_reader;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic       locked;
    logic [6:0] value;
  } exp_t;

  localparam logic [6:0] SEG_TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000
  };
  localparam int STAB [2] = '{4, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_pair_reader_if bus0 ();
  seven_seg_pair_reader_if bus1 ();

  seven_seg_pair_reader #(.STABLE_CNT(4)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  seven_seg_pair_reader #(.STABLE_CNT(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] m_last [2];
  int          m_run  [2];
  bit          m_has  [2];
  bit          m_rep  [2];
  logic [6:0]  m_val  [2];
  bit          m_lock [2];
  exp_t        pipe   [2][3];

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int seg_digit(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (SEG_TBL[d] == s) return d;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_last[i] = '0; m_run[i] = 0; m_has[i] = 0; m_rep[i] = 0;
      m_val[i] = '0; m_lock[i] = 0;
      for (int k = 0; k < 3; k++) pipe[i][k] = '0;
    end
  endtask

  // Reference: length of the current run of identical samples; report once when it reaches STAB.
  task automatic model_step(input int i, input bit smp, input logic [6:0] ten,
                            input logic [6:0] one, output exp_t e);
    int dt, d1, v;
    e = '0;
    if (smp) begin
      if (!m_has[i] || {ten, one} != m_last[i]) begin
        m_has[i] = 1; m_last[i] = {ten, one}; m_run[i] = 1; m_rep[i] = 0; m_lock[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
      end
      if (!m_rep[i] && m_run[i] >= STAB[i]) begin
        m_rep[i] = 1;
        dt = seg_digit(ten);
        d1 = seg_digit(one);
        v  = dt * 10 + d1;
`ifdef SEVEN_SEG_RANGE_CHECK_EN
        if (dt >= 0 && d1 >= 0 && v <= 32) begin
`else
        if (dt >= 0 && d1 >= 0) begin
`endif
          e.valid = 1'b1; m_val[i] = 7'(v); m_lock[i] = 1;
        end else begin
          e.err = 1'b1; m_lock[i] = 0;
        end
      end
    end
    e.value  = m_val[i];
    e.locked = m_lock[i];
  endtask

  task automatic check_outputs(input int i, input exp_t e);
    exp_t o;
    if (i == 0) o = {bus0.o_valid, bus0.o_err, bus0.o_locked, bus0.o_value};
    else        o = {bus1.o_valid, bus1.o_err, bus1.o_locked, bus1.o_value};
    chk($sformatf("u%0d valid t=%0t", i, $time), 7'(o.valid), 7'(e.valid));
    chk($sformatf("u%0d err t=%0t", i, $time), 7'(o.err), 7'(e.err));
    chk($sformatf("u%0d locked t=%0t", i, $time), 7'(o.locked), 7'(e.locked));
    chk($sformatf("u%0d value t=%0t", i, $time), o.value, e.value);
    chk($sformatf("u%0d valid_and_err t=%0t", i, $time), 7'(o.valid & o.err), 7'd0);
  endtask

  task automatic step(input logic [6:0] ten, input logic [6:0] one, input bit smp);
    exp_t e;
    bus0.i_seg_ten = ten; bus0.i_seg_one = one; bus0.i_sample = smp;
    bus1.i_seg_ten = ten; bus1.i_seg_one = one; bus1.i_sample = smp;
    for (int i = 0; i < 2; i++) begin
      model_step(i, smp, ten, one, e);
      pipe[i][2] = pipe[i][1];
      pipe[i][1] = pipe[i][0];
      pipe[i][0] = e;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i, pipe[i][2]);
  endtask

  task automatic hold(input int dt, input int d1, input int n);
    repeat (n) step(SEG_TBL[dt], SEG_TBL[d1], 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(7'h7F, 7'h7F, 1'b0);
  endtask

  task automatic do_reset();
    exp_t z;
    z = '0;
    rst = 1'b1;
    bus0.i_sample = 1'b0; bus1.i_sample = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i, z);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [6:0] rt, ro;
    bit         smp;
    bus0.i_seg_ten = 7'h7F; bus0.i_seg_one = 7'h7F; bus0.i_sample = 1'b0;
    bus1.i_seg_ten = 7'h7F; bus1.i_seg_one = 7'h7F; bus1.i_sample = 1'b0;
    do_reset();
    idle(2);

    // 27 held: one pulse, then quiet.
    hold(2, 7, 8);
    idle(3);
    // 19 for 3 samples, then 20 for 4.
    hold(1, 9, 3);
    hold(2, 0, 4);
    idle(3);
    // Lock at 05, then illegal tens 1111000.
    hold(0, 5, 4);
    repeat (4) step(7'b1111000, SEG_TBL[5], 1'b1);
    idle(3);
    // All segments lit: 88.
    hold(8, 8, 4);
    idle(3);
    // 32 strobed every third cycle.
    for (int k = 0; k < 4; k++) begin
      hold(3, 2, 1);
      idle(2);
    end
    idle(2);
    // Return to a previously locked value reports again.
    hold(2, 7, 4);
    hold(3, 2, 1);
    hold(2, 7, 4);
    idle(3);
    // Reset mid-settle on 12, with samples still in the pipeline.
    hold(1, 2, 3);
    do_reset();
    idle(1);
    hold(1, 2, 4);
    idle(3);
    // Reset right after the reporting strobe: pending pulse must vanish.
    hold(3, 1, 4);
    do_reset();
    idle(4);

    // Random pairs with random hold lengths and sparse strobes.
    repeat (250) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: begin
          rt = SEG_TBL[$urandom_range(0, 3)];
          ro = SEG_TBL[$urandom_range(0, 9)];
        end
        7, 8: begin
          rt = SEG_TBL[$urandom_range(0, 9)];
          ro = SEG_TBL[$urandom_range(0, 9)];
        end
        default: begin
          rt = 7'($urandom);
          ro = SEG_TBL[$urandom_range(0, 9)];
        end
      endcase
      repeat ($urandom_range(1, 6)) begin
        smp = ($urandom_range(0, 3) != 0);
        step(rt, ro, smp);
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_pair_reader.md
# seven_seg_pair_reader

Recovers a two-digit decimal value from a pair of active-low seven-segment patterns (tens, ones) using the DE2_115 digit encoding. It samples on a strobe and requires a configurable number of identical consecutive samples before reporting. It then emits a one-cycle result pulse carrying either the binary value (0..99) or an illegal-pattern error. It sits on the observation side of the HEX display path: it monitors the segment buses driven to HEX displays for on-board self-check and for bench scoreboarding.

## Interface
- `STABLE_CNT`, default 4: consecutive identical samples required before reporting; legal range 1..255.
- `i_clk`  in  1: clock; all logic is on the rising edge.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_seg_ten`  in  7: tens-digit pattern; bit n drives segment n; 1 means dark.
- `i_seg_one`  in  7: ones-digit pattern; same encoding as `i_seg_ten`.
- `i_sample`  in  1: sample strobe; both segment buses are captured on the edge where this is 1.
- `o_value`  out  7: last successfully reported value, 0..99; holds between reports.
- `o_valid`  out  1: one-cycle pulse; `o_value` was updated this cycle.
- `o_err`  out  1: one-cycle pulse; a stable pair contained an illegal pattern, or failed the range check.
- `o_locked`  out  1: level; the current stable pair is legal and has been reported.

## Operation
- Legal patterns, digits 0..9 in order, written as bits 6..0:
  - 0 to 4: 1000000, 1111001, 0100100, 0110000, 0011001.
  - 5 to 9: 0010010, 0000010, 1011000, 0000000, 0010000.
- Every other pattern is illegal. Digit 7 is 1011000 only; 1111000 is illegal.
- Stage 1 (capture): on an edge with `i_sample`=1, register both buses and set internal `cap_v`.
- Stage 2 (decode): on an edge with `cap_v`=1, register the 4-bit tens digit, the 4-bit ones digit, a legal flag, and the raw 14-bit pair. The legal flag is set only if both patterns are legal.
- Stage 3 (stability FSM): updates on an edge with stage-2 valid.
- FSM states are EMPTY, SETTLING and LOCKED.
  - EMPTY (reset state): on any decoded sample, set candidate = raw pair and count = 1, then go to SETTLING.
  - SETTLING, sample equal to candidate: count increments; it saturates at `STABLE_CNT`.
  - SETTLING, sample differs from candidate: candidate = new pair, count = 1.
  - SETTLING, count reaches `STABLE_CNT`: report and go to LOCKED.
  - LOCKED, sample equal to candidate: no action, no pulse.
  - LOCKED, sample differs: candidate = new pair, count = 1, go to SETTLING; `o_locked` drops.
- Comparison is on the raw 14-bit pair, so two different illegal pairs count as different.
- `STABLE_CNT`=1: the first sample of a new pair reports directly; the FSM passes through SETTLING without spending a cycle there.
- Report, legal pair: `o_value` = tens×10 + ones, computed as a 4-bit × constant 10 plus a 4-bit addend into 7 bits; `o_valid`=1 and `o_locked`=1.
- Report, illegal pair: `o_err`=1, `o_value` unchanged, `o_locked`=0.
- Each entry into LOCKED produces exactly one pulse. `o_valid` and `o_err` are never high together.
- A pair that leaves LOCKED and later returns reports again, even if it is the same value.

## Timing
- Reset values: `o_value`=0, `o_valid`=0, `o_err`=0, `o_locked`=0, FSM in EMPTY, count=0, `cap_v`=0.
- Latency: a report caused by the `i_sample` edge in cycle t produces its pulse in cycle t+2.
- Back-to-back `i_sample` strobes (every cycle) are supported with no stalls; the pipeline has no backpressure.
- Without `i_sample`, nothing advances; count and the FSM state hold indefinitely.
- Reset asserted mid-settle or mid-pipeline clears all state immediately. A pulse pending in stage 2 is lost; no pulse appears after reset deasserts.
- `o_locked` changes in the same cycle as the report pulse. It falls in the cycle the differing sample reaches stage 3 (t+2).

## Configuration
- Macro `SEVEN_SEG_RANGE_CHECK_EN`.
- Defined: a legal pair decoding to a value greater than 32 (the upstream decoder's maximum) is treated as illegal. Such a pair gives `o_err` instead of `o_valid`, leaves `o_value` unchanged and keeps `o_locked`=0. This covers the all-lit "88" default output.
- Undefined: every value 0..99 is reported via `o_valid`.

## Test plan
- `STABLE_CNT`=4, ten=0100100, one=1011000, `i_sample` every cycle → exactly one `o_valid`, in the cycle after the fourth strobe's edge plus 1 (t+2), with `o_value`=27 and `o_locked`=1. There are no further pulses while the inputs are held.
- Pair 19 held for 3 samples, then 20 for 4 samples → no pulse for 19. One `o_valid` for 20 follows its 4th sample, with `o_value`=20.
- Locked at 5, then ten=1111000 held 4 samples → one `o_err`; `o_value` stays 5 and `o_locked` drops to 0 when the first 1111000 sample reaches stage 3.
- Pair 0000000/0000000 held 4 samples → with the macro: `o_err`, `o_value` unchanged. Without the macro: `o_valid` with `o_value`=88.
- `i_sample` pulsed every 3rd cycle with a constant pair 32 → pulse 2 cycles after the 4th strobe. Idle gaps do not reset count.
- Reset asserted for 1 cycle after 3 of 4 samples of pair 12, then 4 fresh samples → no pulse before the 4th post-reset sample; pulse `o_value`=12 follows it.
